agc_wb_sequencer: RTL and testbench

AGC_WB_SEQUENCER -- requirements
Module: agc_wb_sequencer

---
 rtl/agc_regmap_pkg.sv | 43 ++++
 rtl/wb_host_xfer.sv | 61 ++++++
 rtl/agc_wb_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_agc_wb_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/agc_regmap_pkg.sv
// Register map, control bits and shared types of the AGC target and its Wishbone sequencer.
package agc_regmap_pkg;

    // Register byte offsets relative to the target base address.
    localparam logic [21:0] RegCtrl   = 22'h00;
    localparam logic [21:0] RegSq     = 22'h04;
    localparam logic [21:0] RegGt     = 22'h08;
    localparam logic [21:0] RegLt     = 22'h0C;
    localparam logic [21:0] RegScale  = 22'h10;
    localparam logic [21:0] RegOffset = 22'h14;

    // Bit positions inside the control/status register.
    localparam int unsigned CtrlTickBit   = 0;
    localparam int unsigned CtrlDoneBit   = 1;
    localparam int unsigned CtrlResetBit  = 2;
    localparam int unsigned CtrlScaleBit  = 8;
    localparam int unsigned CtrlOffsetBit = 9;
    localparam int unsigned CtrlApplyBit  = 10;

    localparam logic [31:0] CtrlTickWord  = 32'(1) << CtrlTickBit;
    localparam logic [31:0] CtrlApplyWord = (32'(1) << CtrlScaleBit) | (32'(1) << CtrlOffsetBit) |
                                            (32'(1) << CtrlApplyBit);

    typedef enum logic [1:0] {
        ErrOk          = 2'd0,
        ErrAckTimeout  = 2'd1,
        ErrPollTimeout = 2'd2
    } agc_err_e;

    typedef enum logic [3:0] {
        StIdle,
        StWrScale,
        StWrOff,
        StWrApply,
        StWrTick,
        StPoll,
        StRdSq,
        StRdGt,
        StRdLt,
        StFinish
    } seq_state_e;

endpackage

// File: rtl/wb_host_xfer.sv
// Single classic Wishbone transfer: holds the strobes until ack or until the ack timeout expires.
module wb_host_xfer #(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        req_we,
    input  logic [21:0] req_adr,
    input  logic [31:0] req_dat,
    input  logic [3:0]  req_sel,
    input  logic        ack,
    output logic        cyc,
    output logic        stb,
    output logic        we,
    output logic [21:0] adr,
    output logic [31:0] dat,
    output logic [3:0]  sel,
    output logic        ack_hit,
    output logic        timeout_hit
);

    localparam int unsigned CntW = $clog2(ACK_TIMEOUT + 1);

    logic [CntW-1:0] wait_cnt;

    // Ack only counts while a cycle is open; stray acks in the gap are ignored.
    assign ack_hit     = cyc & ack;
    assign timeout_hit = cyc & ~ack & (wait_cnt == CntW'(ACK_TIMEOUT - 1));
    assign stb         = cyc;

    // Open a cycle on request, hold all fields, close on ack or timeout (forces a one-cycle gap).
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc      <= 1'b0;
            we       <= 1'b0;
            adr      <= '0;
            dat      <= '0;
            sel      <= '0;
            wait_cnt <= '0;
        end else if (cyc) begin
            if (ack_hit || timeout_hit) begin
                cyc <= 1'b0;
                we  <= 1'b0;
                adr <= '0;
                dat <= '0;
                sel <= '0;
            end else begin
                wait_cnt <= wait_cnt + CntW'(1);
            end
        end else if (req) begin
            cyc      <= 1'b1;
            we       <= req_we;
            adr      <= req_adr;
            dat      <= req_dat;
            sel      <= req_sel;
            wait_cnt <= '0;
        end
    end

endmodule

// File: rtl/agc_wb_sequencer.sv
// Runs one AGC measurement over Wishbone: optional scale/offset load, tick, status poll, readback.
module agc_wb_sequencer
    import agc_regmap_pkg::*;
#(
    parameter logic [21:0] BASE_ADDR   = 22'h000000,
    parameter int unsigned ACK_TIMEOUT = 255,
    parameter int unsigned POLL_LIMIT  = 65535
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        start_i,
    input  logic        load_i,
    input  logic [16:0] scale_i,
    input  logic [7:0]  offset_i,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [21:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [1:0]  err_o,
    output logic [23:0] sq_accum_o,
    output logic [20:0] gt_accum_o,
    output logic [20:0] lt_accum_o
);

    localparam int unsigned PollW = $clog2(POLL_LIMIT + 1);

    seq_state_e       state_q, state_d;
    agc_err_e         err_q, err_d;
    logic [16:0]      scale_q, scale_d;
    logic [7:0]       offset_q, offset_d;
    logic [PollW-1:0] poll_q, poll_d;
    logic [23:0]      sq_q, sq_d;
    logic [20:0]      gt_q, gt_d;
    logic [20:0]      lt_q, lt_d;

    logic        xfer_req, xfer_we, ack_hit, timeout_hit;
    logic [21:0] xfer_off;
    logic [31:0] xfer_dat;
    logic [3:0]  xfer_sel;

    logic unused_dat;
    assign unused_dat = ^wb_dat_i[31:24];

    // Request the next transfer once the engine has closed the previous cycle.
    assign xfer_req = (state_q != StIdle) && (state_q != StFinish) && !wb_cyc_o;

    wb_host_xfer #(
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) u_xfer (
        .clk        (wb_clk_i),
        .rst        (wb_rst_i),
        .req        (xfer_req),
        .req_we     (xfer_we),
        .req_adr    (BASE_ADDR + xfer_off),
        .req_dat    (xfer_dat),
        .req_sel    (xfer_sel),
        .ack        (wb_ack_i),
        .cyc        (wb_cyc_o),
        .stb        (wb_stb_o),
        .we         (wb_we_o),
        .adr        (wb_adr_o),
        .dat        (wb_dat_o),
        .sel        (wb_sel_o),
        .ack_hit    (ack_hit),
        .timeout_hit(timeout_hit)
    );

    // State, captured request and accumulator registers.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q  <= StIdle;
            err_q    <= ErrOk;
            scale_q  <= '0;
            offset_q <= '0;
            poll_q   <= '0;
            sq_q     <= '0;
            gt_q     <= '0;
            lt_q     <= '0;
        end else begin
            state_q  <= state_d;
            err_q    <= err_d;
            scale_q  <= scale_d;
            offset_q <= offset_d;
            poll_q   <= poll_d;
            sq_q     <= sq_d;
            gt_q     <= gt_d;
            lt_q     <= lt_d;
        end
    end

    // Next state and per-state transfer fields.
    always_comb begin
        state_d  = state_q;
        err_d    = err_q;
        scale_d  = scale_q;
        offset_d = offset_q;
        poll_d   = poll_q;
        sq_d     = sq_q;
        gt_d     = gt_q;
        lt_d     = lt_q;
        xfer_we  = 1'b0;
        xfer_off = RegCtrl;
        xfer_dat = '0;
        xfer_sel = 4'b1111;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    scale_d  = scale_i;
                    offset_d = offset_i;
                    err_d    = ErrOk;
                    poll_d   = '0;
                    state_d  = load_i ? StWrScale : StWrTick;
                end
            end
            StWrScale: begin
                xfer_we  = 1'b1;
                xfer_off = RegScale;
                xfer_dat = {15'b0, scale_q};
                xfer_sel = 4'b0111;
                if (ack_hit) state_d = StWrOff;
            end
            StWrOff: begin
                xfer_we  = 1'b1;
                xfer_off = RegOffset;
                xfer_dat = {24'b0, offset_q};
                xfer_sel = 4'b0001;
                if (ack_hit) state_d = StWrApply;
            end
            StWrApply: begin
                xfer_we  = 1'b1;
                xfer_dat = CtrlApplyWord;
                xfer_sel = 4'b0010;
                if (ack_hit) state_d = StWrTick;
            end
            StWrTick: begin
                xfer_we  = 1'b1;
                xfer_dat = CtrlTickWord;
                xfer_sel = 4'b0001;
                if (ack_hit) state_d = StPoll;
            end
            StPoll: begin
                if (ack_hit) begin
                    if (wb_dat_i[CtrlDoneBit]) begin
                        state_d = StRdSq;
                    end else if (poll_q == PollW'(POLL_LIMIT - 1)) begin
                        state_d = StFinish;
                        err_d   = ErrPollTimeout;
                    end else begin
                        poll_d = poll_q + PollW'(1);
                    end
                end
            end
            StRdSq: begin
                xfer_off = RegSq;
                if (ack_hit) begin
                    sq_d    = wb_dat_i[23:0];
                    state_d = StRdGt;
                end
            end
            StRdGt: begin
                xfer_off = RegGt;
                if (ack_hit) begin
                    gt_d    = wb_dat_i[20:0];
                    state_d = StRdLt;
                end
            end
            StRdLt: begin
                xfer_off = RegLt;
                if (ack_hit) begin
                    lt_d    = wb_dat_i[20:0];
                    state_d = StFinish;
                end
            end
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
        if (timeout_hit) begin
            state_d = StFinish;
            err_d   = ErrAckTimeout;
        end
    end

    assign busy_o     = (state_q != StIdle);
    assign done_o     = (state_q == StFinish);
    assign err_o      = err_q;
    assign sq_accum_o = sq_q;
    assign gt_accum_o = gt_q;
    assign lt_accum_o = lt_q;

endmodule

// File: tb/tb_agc_wb_sequencer.sv
// Bench for agc_wb_sequencer: behavioural Wishbone target, transfer log and expected-transfer model.
module tb_agc_wb_sequencer;

    localparam logic [21:0] BaseA = 22'h2A0100;
    localparam logic [21:0] BaseB = 22'h001000;
    localparam int unsigned AckTo = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        start = 1'b0, load = 1'b0;
    logic [16:0] scale = '0;
    logic [7:0]  offset = '0;
    bit          use_b = 1'b0, block_tick = 1'b0, stray_gap = 1'b0;
    int          wait_rd = 0, done_on_poll = 1, poll_base = 0, log_base = 0, done_base = 0;
    logic [31:0] sq_val = '0, gt_val = '0, lt_val = '0;

    logic        cyc_a, stb_a, we_a, busy_a, done_a, ack_a, start_a;
    logic        cyc_b, stb_b, we_b, busy_b, done_b, ack_b, start_b;
    logic [21:0] adr_a, adr_b;
    logic [31:0] dat_a, dat_b, rdata;
    logic [3:0]  sel_a, sel_b;
    logic [1:0]  err_a, err_b;
    logic [23:0] sq_a, sq_b;
    logic [20:0] gt_a, gt_b, lt_a, lt_b;

    assign start_a = start && !use_b;
    assign start_b = start && use_b;

    agc_wb_sequencer #(.BASE_ADDR(BaseA), .ACK_TIMEOUT(AckTo), .POLL_LIMIT(8)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start_a), .load_i(load), .scale_i(scale),
        .offset_i(offset), .wb_cyc_o(cyc_a), .wb_stb_o(stb_a), .wb_we_o(we_a), .wb_adr_o(adr_a),
        .wb_dat_o(dat_a), .wb_sel_o(sel_a), .wb_dat_i(rdata), .wb_ack_i(ack_a), .busy_o(busy_a),
        .done_o(done_a), .err_o(err_a), .sq_accum_o(sq_a), .gt_accum_o(gt_a), .lt_accum_o(lt_a)
    );

    agc_wb_sequencer #(.BASE_ADDR(BaseB), .ACK_TIMEOUT(AckTo), .POLL_LIMIT(4)) dut_p4 (
        .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start_b), .load_i(load), .scale_i(scale),
        .offset_i(offset), .wb_cyc_o(cyc_b), .wb_stb_o(stb_b), .wb_we_o(we_b), .wb_adr_o(adr_b),
        .wb_dat_o(dat_b), .wb_sel_o(sel_b), .wb_dat_i(rdata), .wb_ack_i(ack_b), .busy_o(busy_b),
        .done_o(done_b), .err_o(err_b), .sq_accum_o(sq_b), .gt_accum_o(gt_b), .lt_accum_o(lt_b)
    );

    // Bus of whichever instance is under test.
    logic        m_cyc, m_stb, m_we, m_busy, m_done, m_ack, ack_x;
    logic [21:0] m_adr, m_off;
    logic [31:0] m_dat;
    logic [3:0]  m_sel;
    logic [1:0]  m_err;
    assign m_cyc  = use_b ? cyc_b : cyc_a;
    assign m_stb  = use_b ? stb_b : stb_a;
    assign m_we   = use_b ? we_b : we_a;
    assign m_adr  = use_b ? adr_b : adr_a;
    assign m_dat  = use_b ? dat_b : dat_a;
    assign m_sel  = use_b ? sel_b : sel_a;
    assign m_busy = use_b ? busy_b : busy_a;
    assign m_done = use_b ? done_b : done_a;
    assign m_err  = use_b ? err_b : err_a;
    assign m_off  = m_adr - (use_b ? BaseB : BaseA);

    // Target: reads wait wait_rd cycles, writes ack at once; optionally never acks the tick.
    int wcnt = 0, poll_total = 0;
    logic tick_blocked;
    assign tick_blocked = block_tick && m_we && (m_off == 22'h0) && (m_dat == 32'h1);
    assign m_ack = m_cyc && m_stb && !tick_blocked && (wcnt == (m_we ? 0 : wait_rd));
    assign ack_x = m_ack || (stray_gap && !m_cyc);
    assign ack_a = !use_b && ack_x;
    assign ack_b = use_b && ack_x;

    always_comb begin
        rdata = 32'h0;
        case (m_off)
            22'h00: rdata = 32'hA5A5A5A5 |
                ((done_on_poll != 0 && poll_total - poll_base + 1 >= done_on_poll) ? 32'h2 : 32'h0);
            22'h04: rdata = sq_val;
            22'h08: rdata = gt_val;
            22'h0C: rdata = lt_val;
            default: rdata = 32'hDEAD0000;
        endcase
    end

    // Bus monitor: logs acked transfers and counts protocol violations and done pulses.
    logic [58:0] log_q[$];
    logic [58:0] hold = '0;
    logic        hold_v = 1'b0, prev_ack = 1'b0;
    int          stab_err = 0, gap_err = 0, done_cnt = 0, cyc_len = 0, last_cyc_len = 0;
    logic [1:0]  last_err = '0;
    always @(posedge clk) begin
        wcnt <= (m_cyc && !m_ack) ? wcnt + 1 : 0;
        if (m_cyc && m_ack) begin
            log_q.push_back({m_we, m_adr, m_dat, m_sel});
            if (!m_we && m_off == 22'h0) poll_total <= poll_total + 1;
        end
        hold_v   <= m_cyc && !m_ack;
        hold     <= {m_we, m_adr, m_dat, m_sel};
        prev_ack <= m_cyc && m_ack;
        if ((hold_v && m_cyc && hold != {m_we, m_adr, m_dat, m_sel}) || (m_stb != m_cyc) ||
            (m_cyc && !m_we && (m_sel != 4'hF || m_dat != 32'h0)))
            stab_err <= stab_err + 1;
        if (prev_ack && m_cyc) gap_err <= gap_err + 1;
        if (m_cyc) cyc_len <= cyc_len + 1;
        else begin
            if (cyc_len != 0) last_cyc_len <= cyc_len;
            cyc_len <= 0;
        end
        if (m_done) begin
            done_cnt <= done_cnt + 1;
            last_err <= m_err;
        end
    end

    int checks = 0, failures = 0;
    logic [58:0] exp_q[$];
    logic [23:0] exp_sq = '0;
    logic [20:0] exp_gt = '0, exp_lt = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Expected transfer list straight from the register-level sequence.
    task automatic build_exp(input logic [21:0] base, input bit ld, input logic [16:0] sc,
                             input logic [7:0] of, input int npolls, input bit reads);
        exp_q.delete();
        if (ld) begin
            exp_q.push_back({1'b1, base + 22'h10, {15'b0, sc}, 4'b0111});
            exp_q.push_back({1'b1, base + 22'h14, {24'b0, of}, 4'b0001});
            exp_q.push_back({1'b1, base, 32'h00000700, 4'b0010});
        end
        exp_q.push_back({1'b1, base, 32'h00000001, 4'b0001});
        for (int i = 0; i < npolls; i++) exp_q.push_back({1'b0, base, 32'h0, 4'hF});
        if (reads) begin
            exp_q.push_back({1'b0, base + 22'h04, 32'h0, 4'hF});
            exp_q.push_back({1'b0, base + 22'h08, 32'h0, 4'hF});
            exp_q.push_back({1'b0, base + 22'h0C, 32'h0, 4'hF});
        end
    endtask

    task automatic compare_log(input string tag);
        check({tag, "_nxfer"}, 64'(log_q.size() - log_base), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            if (log_base + i < log_q.size())
                check($sformatf("%s_xfer%0d", tag, i), 64'(log_q[log_base + i]), 64'(exp_q[i]));
    endtask

    task automatic run_meas(input bit ld, input logic [16:0] sc, input logic [7:0] of,
                            input bit spurious, output int lat);
        int n;
        lat = 0;
        @(negedge clk);
        load = ld; scale = sc; offset = of; start = 1'b1;
        poll_base = poll_total; log_base = log_q.size(); done_base = done_cnt;
        @(negedge clk);
        start = 1'b0; load = ~ld; scale = ~sc; offset = ~of;
        for (n = 0; n < 3000; n++) begin
            if (m_busy) lat++;
            if (m_done) break;
            start = spurious && (n == 2);
            @(negedge clk);
        end
        start = 1'b0;
        check("done_seen", 64'(m_done), 64'd1);
        @(negedge clk);
        check("done_one_cycle", 64'({m_done, m_busy}), 64'd0);
        check("done_count", 64'(done_cnt - done_base), 64'd1);
    endtask

    task automatic check_accums(input string tag);
        check({tag, "_acc"}, 64'({sq_a, gt_a, lt_a}), 64'({exp_sq, exp_gt, exp_lt}));
    endtask

    task automatic new_values();
        sq_val = $urandom(); gt_val = $urandom(); lt_val = $urandom();
    endtask

    initial begin
        int lat;
        bit found;
        bit ld;
        logic [16:0] sc;
        logic [7:0] of;

        // Reset state of both instances.
        repeat (3) @(negedge clk);
        check("rst_bus_a", 64'({cyc_a, stb_a, we_a, adr_a, dat_a, sel_a}), 64'd0);
        check("rst_ctl_a", 64'({busy_a, done_a, err_a, sq_a, gt_a, lt_a}), 64'd0);
        check("rst_bus_b", 64'({cyc_b, stb_b, we_b, adr_b, dat_b, sel_b}), 64'd0);
        check("rst_ctl_b", 64'({busy_b, done_b, err_b, sq_b, gt_b, lt_b}), 64'd0);
        rst = 1'b0;

        // Stray acks while idle must not start anything.
        stray_gap = 1'b1;
        repeat (4) @(negedge clk);
        stray_gap = 1'b0;
        check("stray_idle", 64'({busy_a, cyc_a, sq_a}), 64'd0);

        // No load, zero-wait target, done on the first poll.
        sq_val = 32'hFF123456; gt_val = 32'hFFEABCDE; lt_val = 32'h1200F00D;
        wait_rd = 0; done_on_poll = 1;
        run_meas(1'b0, 17'h0, 8'h0, 1'b0, lat);
        build_exp(BaseA, 1'b0, 17'h0, 8'h0, 1, 1'b1);
        compare_log("basic");
        check("basic_lat", 64'(lat), 64'd11);
        check("basic_err", 64'(last_err), 64'd0);
        exp_sq = 24'h123456; exp_gt = 21'h0ABCDE; exp_lt = 21'h00F00D;
        check_accums("basic");

        // Load path, with a start pulse while busy that must be ignored.
        new_values();
        run_meas(1'b1, 17'h1ABCD, 8'h5A, 1'b1, lat);
        build_exp(BaseA, 1'b1, 17'h1ABCD, 8'h5A, 1, 1'b1);
        compare_log("load");
        check("load_lat", 64'(lat), 64'd17);
        exp_sq = sq_val[23:0]; exp_gt = gt_val[20:0]; exp_lt = lt_val[20:0];
        check_accums("load");

        // Read wait states, done on the 7th poll.
        new_values();
        wait_rd = 3; done_on_poll = 7;
        run_meas(1'b0, 17'h0, 8'h0, 1'b0, lat);
        build_exp(BaseA, 1'b0, 17'h0, 8'h0, 7, 1'b1);
        compare_log("wait7");
        check("wait7_err", 64'(last_err), 64'd0);
        exp_sq = sq_val[23:0]; exp_gt = gt_val[20:0]; exp_lt = lt_val[20:0];
        check_accums("wait7");

        // Random measurements with stray acks in the inter-transfer gaps.
        stray_gap = 1'b1;
        for (int k = 0; k < 4; k++) begin
            new_values();
            wait_rd = $urandom_range(0, 3); done_on_poll = $urandom_range(1, 5);
            ld = 1'($urandom_range(0, 1)); sc = 17'($urandom()); of = 8'($urandom());
            run_meas(ld, sc, of, 1'b0, lat);
            build_exp(BaseA, ld, sc, of, done_on_poll, 1'b1);
            compare_log($sformatf("rnd%0d", k));
            check($sformatf("rnd%0d_err", k), 64'(last_err), 64'd0);
            exp_sq = sq_val[23:0]; exp_gt = gt_val[20:0]; exp_lt = lt_val[20:0];
            check_accums($sformatf("rnd%0d", k));
        end
        stray_gap = 1'b0;

        // Tick never acked: ack timeout.
        new_values();
        block_tick = 1'b1; wait_rd = 0; done_on_poll = 1;
        run_meas(1'b0, 17'h0, 8'h0, 1'b0, lat);
        block_tick = 1'b0;
        exp_q.delete();
        compare_log("ackto");
        check("ackto_err", 64'(last_err), 64'd1);
        check("ackto_cyc_len", 64'(last_cyc_len), 64'(AckTo));
        check("ackto_lat", 64'(lat), 64'(AckTo + 2));
        check_accums("ackto");

        // Poll limit of 4 on the second instance, done never set.
        use_b = 1'b1; done_on_poll = 0; wait_rd = $urandom_range(0, 2);
        run_meas(1'b0, 17'h0, 8'h0, 1'b0, lat);
        build_exp(BaseB, 1'b0, 17'h0, 8'h0, 4, 1'b0);
        compare_log("pollto");
        check("pollto_err", 64'(last_err), 64'd2);
        check("pollto_acc", 64'({sq_b, gt_b, lt_b}), 64'd0);
        use_b = 1'b0;

        // Reset in the middle of the gt read, then a clean measurement.
        new_values();
        wait_rd = 3; done_on_poll = 1; done_base = done_cnt;
        @(negedge clk);
        start = 1'b1; load = 1'b0;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int n = 0; n < 500 && !found; n++) begin
            @(negedge clk);
            if (cyc_a && adr_a == BaseA + 22'h08) found = 1'b1;
        end
        check("rst_reach_rdgt", 64'(found), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_bus", 64'({cyc_a, stb_a, we_a, adr_a, dat_a, sel_a}), 64'd0);
        check("midrst_ctl", 64'({busy_a, done_a, err_a, sq_a, gt_a, lt_a}), 64'd0);
        repeat (5) @(negedge clk);
        check("midrst_nodone", 64'(done_cnt - done_base), 64'd0);
        exp_sq = '0; exp_gt = '0; exp_lt = '0;
        new_values();
        run_meas(1'b0, 17'h0, 8'h0, 1'b0, lat);
        build_exp(BaseA, 1'b0, 17'h0, 8'h0, 1, 1'b1);
        compare_log("postrst");
        check("postrst_err", 64'(last_err), 64'd0);
        exp_sq = sq_val[23:0]; exp_gt = gt_val[20:0]; exp_lt = lt_val[20:0];
        check_accums("postrst");

        check("bus_hold_violations", 64'(stab_err), 64'd0);
        check("bus_gap_violations", 64'(gap_err), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
